// File: rtl/nbf_uart_host_link.sv
// Host-side NBF link: serialises commands to a UART byte stream, reassembles
// responses, and checks them against a FIFO of expected headers with a response timeout.
module nbf_uart_host_link #(
  parameter int nbf_addr_width_p  = 40,
  parameter int nbf_data_width_p  = 64,
  parameter int max_outstanding_p = 4,
  parameter int timeout_cycles_p  = 1000000,
  localparam int nbf_width_lp = 8 + nbf_addr_width_p + nbf_data_width_p,
  localparam int nbf_bytes_lp = (nbf_width_lp + 7) / 8,
  localparam int out_w_lp     = $clog2(max_outstanding_p + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_v_i,
  input  logic [nbf_width_lp-1:0] cmd_nbf_i,
  output logic                    cmd_ready_and_o,
  output logic                    tx_v_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_ready_and_i,
  input  logic                    rx_v_i,
  input  logic [7:0]              rx_data_i,
  output logic                    resp_v_o,
  output logic [nbf_width_lp-1:0] resp_nbf_o,
  output logic                    resp_mismatch_o,
  input  logic                    resp_ready_and_i,
  output logic [out_w_lp-1:0]     outstanding_o,
  output logic                    err_timeout_o,
  output logic                    err_overflow_o,
  output logic                    err_unexpected_o,
  input  logic                    clear_err_i
);

  localparam int pad_w_lp  = nbf_bytes_lp * 8;
  localparam int hdr_w_lp  = 8 + nbf_addr_width_p;
  localparam int bidx_w_lp = (nbf_bytes_lp > 1) ? $clog2(nbf_bytes_lp) : 1;
  localparam int ptr_w_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int to_w_lp   = $clog2(timeout_cycles_p + 1);

  localparam logic [bidx_w_lp-1:0] last_byte_lp = bidx_w_lp'(nbf_bytes_lp - 1);
  localparam logic [out_w_lp-1:0]  max_out_lp   = out_w_lp'(max_outstanding_p);
  localparam logic [to_w_lp-1:0]   to_last_lp   = to_w_lp'(timeout_cycles_p - 1);
  localparam logic [ptr_w_lp-1:0]  ptr_last_lp  = ptr_w_lp'(max_outstanding_p - 1);

  typedef enum logic {IDLE, SEND} tx_state_e;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_last_lp) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [bidx_w_lp-1:0] byte_inc(input logic [bidx_w_lp-1:0] b);
    return (b == last_byte_lp) ? '0 : b + 1'b1;
  endfunction

  tx_state_e             state_r, state_n;
  logic                  up_r;
  logic [pad_w_lp-1:0]   tx_shift_r;
  logic [bidx_w_lp-1:0]  tx_idx_r;
  logic [pad_w_lp-1:0]   cmd_pad;
  logic                  cmd_accept;
  logic                  tx_hs;

  logic [hdr_w_lp-1:0]   fifo_mem [max_outstanding_p];
  logic [ptr_w_lp-1:0]   wr_ptr_r, rd_ptr_r;
  logic [out_w_lp-1:0]   count_r, count_n;
  logic                  fifo_empty;
  logic [hdr_w_lp-1:0]   cmd_hdr, exp_hdr, rx_hdr;

  logic [pad_w_lp-9:0]   rx_buf_r;
  logic [bidx_w_lp-1:0]  rx_idx_r;
  logic [pad_w_lp-1:0]   rx_pkt_pad;
  logic [nbf_width_lp-1:0] rx_pkt;
  logic                  rx_done;

  logic                  resp_v_r, resp_mismatch_r;
  logic [nbf_width_lp-1:0] resp_nbf_r;
  logic                  slot_free, resp_load, fifo_pop, resp_drop, unexpected;

  logic [to_w_lp-1:0]    to_cnt_r;
  logic                  to_active, to_fire;

  always_comb begin
    cmd_pad = '0;
    cmd_pad[nbf_width_lp-1:0] = cmd_nbf_i;
  end

  assign cmd_hdr = cmd_nbf_i[nbf_width_lp-1:nbf_data_width_p];

  // TX FSM: accept one command in IDLE, stream its bytes LSB first in SEND
  always_comb begin
    state_n         = state_r;
    cmd_ready_and_o = 1'b0;
    tx_v_o          = 1'b0;
    case (state_r)
      IDLE: begin
        cmd_ready_and_o = up_r && (count_r < max_out_lp);
        if (cmd_v_i && cmd_ready_and_o) state_n = SEND;
      end
      SEND: begin
        tx_v_o = 1'b1;
        if (tx_ready_and_i && (tx_idx_r == last_byte_lp)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign cmd_accept = cmd_v_i & cmd_ready_and_o;
  assign tx_hs      = tx_v_o & tx_ready_and_i;
  assign tx_data_o  = tx_shift_r[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      up_r       <= 1'b0;
      tx_shift_r <= '0;
      tx_idx_r   <= '0;
    end else begin
      state_r <= state_n;
      up_r    <= 1'b1;
      if (cmd_accept) begin
        tx_shift_r <= cmd_pad;
        tx_idx_r   <= '0;
      end else if (tx_hs) begin
        tx_shift_r <= {8'h00, tx_shift_r[pad_w_lp-1:8]};
        tx_idx_r   <= byte_inc(tx_idx_r);
      end
    end
  end

  // RX assembly: bytes shift in from the top so byte 0 lands in the LSBs
  assign rx_done    = rx_v_i && (rx_idx_r == last_byte_lp);
  assign rx_pkt_pad = {rx_data_i, rx_buf_r};
  assign rx_pkt     = rx_pkt_pad[nbf_width_lp-1:0];
  assign rx_hdr     = rx_pkt[nbf_width_lp-1:nbf_data_width_p];

  assign fifo_empty = (count_r == '0);
  assign exp_hdr    = fifo_mem[rd_ptr_r];
  assign slot_free  = !resp_v_r || resp_ready_and_i;
  assign resp_load  = rx_done && slot_free;
  assign resp_drop  = rx_done && !slot_free;
  assign fifo_pop   = rx_done && !fifo_empty;
  assign unexpected = rx_done && fifo_empty;

  assign to_active = (rx_idx_r != '0) || (count_r != '0);
  assign to_fire   = !rx_v_i && to_active && (to_cnt_r == to_last_lp);

  // On a timeout flush, a push in the same cycle survives as the sole entry
  always_comb begin
    count_n = count_r;
    if (to_fire) count_n = out_w_lp'(cmd_accept);
    else if (cmd_accept && !fifo_pop) count_n = count_r + 1'b1;
    else if (!cmd_accept && fifo_pop) count_n = count_r - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < max_outstanding_p; i++) fifo_mem[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      count_r <= count_n;
      if (cmd_accept) begin
        fifo_mem[wr_ptr_r] <= cmd_hdr;
        wr_ptr_r           <= ptr_inc(wr_ptr_r);
      end
      if (to_fire) rd_ptr_r <= wr_ptr_r;
      else if (fifo_pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_buf_r <= '0;
      rx_idx_r <= '0;
    end else begin
      if (rx_v_i) rx_buf_r <= {rx_data_i, rx_buf_r[pad_w_lp-9:8]};
      if (to_fire) rx_idx_r <= '0;
      else if (rx_v_i) rx_idx_r <= byte_inc(rx_idx_r);
    end
  end

  // Single-entry response slot and timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_v_r        <= 1'b0;
      resp_nbf_r      <= '0;
      resp_mismatch_r <= 1'b0;
      to_cnt_r        <= '0;
    end else begin
      if (resp_load) begin
        resp_v_r        <= 1'b1;
        resp_nbf_r      <= rx_pkt;
        resp_mismatch_r <= fifo_empty || (rx_hdr != exp_hdr);
      end else if (resp_ready_and_i) begin
        resp_v_r <= 1'b0;
      end
      if (rx_v_i || !to_active || to_fire) to_cnt_r <= '0;
      else to_cnt_r <= to_cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout_o    <= 1'b0;
      err_overflow_o   <= 1'b0;
      err_unexpected_o <= 1'b0;
    end else begin
      err_timeout_o    <= (err_timeout_o & ~clear_err_i) | to_fire;
      err_overflow_o   <= (err_overflow_o & ~clear_err_i) | resp_drop;
      err_unexpected_o <= (err_unexpected_o & ~clear_err_i) | unexpected;
    end
  end

  assign resp_v_o        = resp_v_r;
  assign resp_nbf_o      = resp_nbf_r;
  assign resp_mismatch_o = resp_mismatch_r;
  assign outstanding_o   = count_r;

endmodule

// File: tb/tb_nbf_uart_host_link.sv
// Directed bench for nbf_uart_host_link with TX byte and response scoreboards.
module tb_nbf_uart_host_link;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_v_i = 1'b0;
  logic [111:0] cmd_nbf_i = '0;
  logic         cmd_ready_and_o;
  logic         tx_v_o;
  logic [7:0]   tx_data_o;
  logic         tx_ready_and_i = 1'b1;
  logic         rx_v_i = 1'b0;
  logic [7:0]   rx_data_i = '0;
  logic         resp_v_o;
  logic [111:0] resp_nbf_o;
  logic         resp_mismatch_o;
  logic         resp_ready_and_i = 1'b1;
  logic [2:0]   outstanding_o;
  logic         err_timeout_o, err_overflow_o, err_unexpected_o;
  logic         clear_err_i = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0]   tx_q [$];
  logic [112:0] resp_q [$];
  logic [7:0]   tx_log [64];
  int           tx_cnt = 0;

  nbf_uart_host_link #(.timeout_cycles_p(100)) dut (
    .clk(clk), .reset(reset),
    .cmd_v_i(cmd_v_i), .cmd_nbf_i(cmd_nbf_i), .cmd_ready_and_o(cmd_ready_and_o),
    .tx_v_o(tx_v_o), .tx_data_o(tx_data_o), .tx_ready_and_i(tx_ready_and_i),
    .rx_v_i(rx_v_i), .rx_data_i(rx_data_i),
    .resp_v_o(resp_v_o), .resp_nbf_o(resp_nbf_o), .resp_mismatch_o(resp_mismatch_o),
    .resp_ready_and_i(resp_ready_and_i), .outstanding_o(outstanding_o),
    .err_timeout_o(err_timeout_o), .err_overflow_o(err_overflow_o),
    .err_unexpected_o(err_unexpected_o), .clear_err_i(clear_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [111:0] mk(input logic [7:0] op, input logic [39:0] a, input logic [63:0] d);
    return {op, a, d};
  endfunction

  // Monitors sample on the falling edge; inputs change just after the rising edge
  always @(negedge clk) begin
    if (!reset && tx_v_o && tx_ready_and_i) begin
      if (tx_q.size() == 0) chk("tx_extra_byte", 1, 0);
      else chk("tx_byte", tx_data_o, tx_q.pop_front());
      if (tx_cnt < 64) tx_log[tx_cnt] = tx_data_o;
      tx_cnt++;
    end
    if (!reset && resp_v_o && resp_ready_and_i) begin
      if (resp_q.size() == 0) chk("resp_extra", 1, 0);
      else begin
        logic [112:0] e;
        e = resp_q.pop_front();
        chk("resp_nbf", resp_nbf_o, e[111:0]);
        chk("resp_mismatch", resp_mismatch_o, e[112]);
      end
    end
  end

  task automatic push_bytes(input logic [111:0] p);
    for (int k = 0; k < 14; k++) tx_q.push_back(p[8*k +: 8]);
  endtask

  task automatic send_cmd(input logic [111:0] p);
    int n;
    n = 0;
    cmd_nbf_i = p;
    cmd_v_i = 1'b1;
    @(negedge clk);
    while (!cmd_ready_and_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("cmd_accept_wait", 0, 1);
    else push_bytes(p);
    @(posedge clk); #1;
    cmd_v_i = 1'b0;
  endtask

  task automatic wait_tx_done();
    int n;
    for (n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (tx_q.size() == 0 && !tx_v_o) break;
    end
    if (n >= 300) chk("tx_done_wait", 0, 1);
  endtask

  task automatic wait_resp_done();
    int n;
    for (n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (resp_q.size() == 0) break;
    end
    if (n >= 300) chk("resp_done_wait", 0, 1);
  endtask

  task automatic send_resp(input logic [111:0] p, input int nbytes, input bit deliver,
                           input bit mm, input bit with_cmd, input logic [111:0] c);
    if (deliver) resp_q.push_back({mm, p});
    for (int k = 0; k < nbytes; k++) begin
      @(posedge clk); #1;
      rx_v_i = 1'b1;
      rx_data_i = p[8*k +: 8];
      if (with_cmd && k == nbytes - 1) begin
        cmd_v_i = 1'b1;
        cmd_nbf_i = c;
        @(negedge clk);
        chk("coincident_ready", cmd_ready_and_o, 1);
        push_bytes(c);
      end
    end
    @(posedge clk); #1;
    rx_v_i = 1'b0;
    cmd_v_i = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear_err_i = 1'b1;
    @(posedge clk); #1;
    clear_err_i = 1'b0;
  endtask

  initial begin
    logic [111:0] c1, x, e1, e2, t1, f1, f2, r;
    logic [111:0] cc [4];
    int n;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready_and_o, 0);
    chk("rst_tx_v", tx_v_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_errs", {err_timeout_o, err_overflow_o, err_unexpected_o}, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ready", cmd_ready_and_o, 1);

    // reset in the middle of a transmission
    x = mk(8'h11, 40'h12_3456_789A, 64'h0102_0304_0506_0708);
    tx_cnt = 0;
    send_cmd(x);
    n = 0;
    while (tx_cnt < 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("mid_send_wait", 0, 1);
    reset = 1'b1;
    #1;
    tx_q.delete();
    chk("midrst_tx_v", tx_v_o, 0);
    chk("midrst_outstanding", outstanding_o, 0);
    chk("midrst_ready", cmd_ready_and_o, 0);
    chk("midrst_bytes_sent", tx_cnt, 5);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_ready_after", cmd_ready_and_o, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_residual", tx_v_o, 0);

    // single command and matching echo
    c1 = mk(8'h03, 40'h00_8000_0000, 64'hAB);
    tx_cnt = 0;
    send_cmd(c1);
    wait_tx_done();
    chk("c1_byte_count", tx_cnt, 14);
    chk("c1_byte0", tx_log[0], 8'hAB);
    chk("c1_bytes8_12", {tx_log[12], tx_log[11], tx_log[10], tx_log[9], tx_log[8]}, 40'h00_8000_0000);
    chk("c1_byte13", tx_log[13], 8'h03);
    chk("c1_outstanding1", outstanding_o, 1);
    send_resp(mk(8'h03, 40'h00_8000_0000, 64'h5555), 14, 1, 0, 0, '0);
    wait_resp_done();
    chk("c1_outstanding0", outstanding_o, 0);

    // four in flight, fifth blocked, third response with a wrong address
    for (int i = 0; i < 4; i++) begin
      cc[i] = mk(8'h01 + 8'(i), 40'h1000 + 40'(i * 64), 64'(i + 1));
      send_cmd(cc[i]);
    end
    wait_tx_done();
    chk("four_outstanding", outstanding_o, 4);
    cmd_nbf_i = mk(8'h09, 40'h9, 64'h9);
    cmd_v_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fifth_blocked", cmd_ready_and_o, 0);
    end
    @(posedge clk); #1;
    cmd_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = cc[i];
      r[63:0] = 64'hD0 + 64'(i);
      if (i == 2) r[103:64] = r[103:64] + 40'd8;
      send_resp(r, 14, 1, (i == 2), 0, '0);
    end
    wait_resp_done();
    chk("four_drained", outstanding_o, 0);

    // held slot forces a drop
    e1 = mk(8'h21, 40'h2100, 64'hE1);
    e2 = mk(8'h22, 40'h2200, 64'hE2);
    send_cmd(e1);
    send_cmd(e2);
    wait_tx_done();
    resp_ready_and_i = 1'b0;
    send_resp(e1, 14, 1, 0, 0, '0);
    send_resp(e2, 14, 0, 0, 0, '0);
    chk("ovf_err", err_overflow_o, 1);
    chk("ovf_outstanding", outstanding_o, 0);
    chk("ovf_held_v", resp_v_o, 1);
    chk("ovf_held_pkt", resp_nbf_o, e1);
    resp_ready_and_i = 1'b1;
    wait_resp_done();
    pulse_clear();
    chk("ovf_cleared", err_overflow_o, 0);

    // partial response then silence
    t1 = mk(8'h31, 40'h3100, 64'h31);
    send_cmd(t1);
    wait_tx_done();
    send_resp(t1, 7, 0, 0, 0, '0);
    n = 0;
    while (!err_timeout_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_cycles", n, 100);
    chk("timeout_outstanding", outstanding_o, 0);
    send_resp(t1, 14, 1, 1, 0, '0);
    wait_resp_done();
    chk("unexpected_err", err_unexpected_o, 1);
    pulse_clear();
    chk("errs_cleared", {err_timeout_o, err_overflow_o, err_unexpected_o}, 0);

    // accept on the same edge as a response completes
    f1 = mk(8'h41, 40'h4100, 64'h41);
    f2 = mk(8'h42, 40'h4200, 64'h42);
    send_cmd(f1);
    wait_tx_done();
    chk("coinc_before", outstanding_o, 1);
    send_resp(f1, 14, 1, 0, 1, f2);
    chk("coinc_after", outstanding_o, 1);
    wait_tx_done();
    send_resp(f2, 14, 1, 0, 0, '0);
    wait_resp_done();
    chk("coinc_drained", outstanding_o, 0);
    chk("coinc_errs", {err_timeout_o, err_overflow_o, err_unexpected_o}, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("tx_queue_empty", tx_q.size(), 0);
    chk("resp_queue_empty", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nbf_uart_host_link.md
Name: nbf_uart_host_link

Overview:
- Host-side NBF link engine for the FPGA host path.
- Serialises NBF command packets into a byte stream for a UART TX.
- Deserialises response bytes from a UART RX back into NBF packets.
- Tracks up to max_outstanding_p in-flight commands, checks each response's opcode/addr against its command, and enforces a response timeout; flags errors as sticky bits.

Parameters:
- nbf_addr_width_p, 40: NBF address field width.
- nbf_data_width_p, 64: NBF data field width.
- max_outstanding_p, 4: expected-header FIFO depth (power of 2, >=1).
- timeout_cycles_p, 1000000: idle cycles before a pending or partial response is abandoned.
- Derived: nbf_width_lp = 8+nbf_addr_width_p+nbf_data_width_p; nbf_bytes_lp = ceil(nbf_width_lp/8) (14 at defaults). Packet layout {opcode[7:0], addr, data}, data in LSBs, zero-padded to nbf_bytes_lp*8.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cmd_v_i  in  1  command valid
- cmd_nbf_i  in  nbf_width_lp  command packet
- cmd_ready_and_o  out  1  command accepted when high with cmd_v_i
- tx_v_o  out  1  byte valid to UART TX
- tx_data_o  out  8  byte to UART TX
- tx_ready_and_i  in  1  UART TX accepts byte
- rx_v_i  in  1  one-cycle pulse, byte received (no backpressure)
- rx_data_i  in  8  received byte
- resp_v_o  out  1  response valid
- resp_nbf_o  out  nbf_width_lp  response packet
- resp_mismatch_o  out  1  opcode/addr mismatch vs. expected, qualified by resp_v_o
- resp_ready_and_i  in  1  consumer accepts response
- outstanding_o  out  clog2(max_outstanding_p+1)  in-flight command count
- err_timeout_o  out  1  sticky
- err_overflow_o  out  1  sticky
- err_unexpected_o  out  1  sticky
- clear_err_i  in  1  clears sticky errors

Behaviour:
- Reset: all registers clear asynchronously; all outputs 0, including cmd_ready_and_o. No reset of partial packets beyond this.
- Byte order, both directions: byte k = packet[8k+:8], k = 0 first (LSB first).
- TX FSM IDLE/SEND:
  - IDLE: cmd_ready_and_o = (outstanding_o < max_outstanding_p).
  - On accept: latch packet, push {opcode, addr} to expected FIFO, outstanding+1, go to SEND.
  - SEND: tx_v_o=1, tx_data_o=byte[idx], cmd_ready_and_o=0. idx increments on tx handshake; after byte nbf_bytes_lp-1, return to IDLE.
  - tx_v_o first rises the cycle after acceptance. tx_v_o/tx_data_o hold stable until handshake.
- RX assembler:
  - On rx_v_i, store byte at rx_idx, then increment.
  - On last byte the packet completes (same edge) and rx_idx wraps to 0.
- Completion, resp slot empty or being consumed this cycle:
  - Load resp_nbf_o; resp_v_o=1 next cycle.
  - Pop expected FIFO.
  - resp_mismatch_o = opcode or addr differ from popped entry.
- Completion, expected FIFO empty: deliver response with resp_mismatch_o=1; set err_unexpected_o; no pop.
- Completion, resp slot full and not consumed: drop packet, still pop FIFO (keeps alignment), set err_overflow_o.
- Response slot: holds until resp_v_o & resp_ready_and_i. Single entry.
- Outstanding count:
  - Push and pop in the same cycle: count unchanged.
  - Count decrements on pop, not on consumer accept.
- Timeout:
  - Counter increments each cycle while (rx_idx != 0 || outstanding != 0) and no rx_v_i. Clears on rx_v_i or when both are zero.
  - At timeout_cycles_p: discard partial RX packet (rx_idx=0), flush expected FIFO (outstanding=0), set err_timeout_o, clear counter.
  - If an accept coincides with timeout, the flush wins and the new push is retained (outstanding=1).
- Sticky errors: clear_err_i clears them; a new error event in the same cycle as clear_err_i leaves the bit set.
- Mid-packet TX is never aborted by timeout.

Test Plan:
- Reset mid-SEND (after 5 bytes): tx_v_o, outstanding_o, cmd_ready_and_o immediately 0; after release, cmd_ready_and_o=1 and no residual bytes.
- Command {op=8'h03, addr=40'h00_8000_0000, data=64'hAB}: 14 bytes out, byte0=8'hAB, bytes 8..12 = 00,00,00,80,00, byte13=8'h03. Echo same header back: resp_v_o=1, resp_mismatch_o=0, outstanding_o 1->0.
- Four commands back to back: fifth blocked (cmd_ready_and_o=0). Responses in order, third with addr+8: only third flags resp_mismatch_o.
- Two responses with resp_ready_and_i=0: first held; second dropped; err_overflow_o=1; outstanding_o=0. clear_err_i clears it.
- 7 response bytes then silence for timeout_cycles_p (bench sets 100): err_timeout_o=1, outstanding_o=0. A subsequent full response gives err_unexpected_o=1, resp_mismatch_o=1.
- Accept cycle coincident with last-byte RX completion: outstanding_o unchanged; both packets handled correctly.
